// File: rtl/hazard_scoreboard_unit_if.sv
// rtl/hazard_scoreboard_unit_if.sv - ID/EX hazard bundle between pipeline control and hazard unit
// The master side drives the ID instruction; the slave side returns stall/flush/forward controls.
interface hazard_scoreboard_unit_if #(
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [31:0]      id_instr;
   logic             branch_taken;
   logic             stall;
   logic             id_flush;
   logic             ex_valid;
   logic [1:0]       ex_fwd_a;
   logic [1:0]       ex_fwd_b;
   logic             illegal;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_valid, id_instr, branch_taken,
      input  stall, id_flush, ex_valid, ex_fwd_a, ex_fwd_b, illegal, stall_cycles
   );

   modport slave (
      input  id_valid, id_instr, branch_taken,
      output stall, id_flush, ex_valid, ex_fwd_a, ex_fwd_b, illegal, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - RISC-V 5-stage hazard scoreboard with stall, flush and forwarding
// Per-register countdown scoreboard plus an EX/MEM destination shift register.
module hazard_scoreboard_unit #(
   parameter int NREG     = 32,
   parameter int RAW      = $clog2(NREG),
   parameter int LOAD_LAT = 1,
   parameter int FWD_EN   = 1,
   parameter int CNT_W    = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   hazard_scoreboard_unit_if.slave hs
);
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic [RAW-1:0]       rs1, rs2, rd;
   logic                 use_rs1, use_rs2, dec_wen, dec_load, dec_ill;
   logic                 rs1_hz, rs2_hz, stall, issue, wr_issue;
   logic [1:0]           set_val;
   logic [NREG-1:0][1:0] cnt_q, cnt_d;
   logic [RAW-1:0]       ex_rd_q, mem_rd_q;
   logic                 ex_wen_q, mem_wen_q, ex_valid_q;
   logic [1:0]           fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
   logic [CNT_W-1:0]     stall_cycles_q;
   logic                 unused_instr;

   assign rs1          = hs.id_instr[15 +: RAW];
   assign rs2          = hs.id_instr[20 +: RAW];
   assign rd           = hs.id_instr[7 +: RAW];
   assign unused_instr = ^{hs.id_instr[31:25], hs.id_instr[14:12]};

   always_comb begin
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      dec_wen  = 1'b0;
      dec_load = 1'b0;
      dec_ill  = 1'b0;
      case (hs.id_instr[6:0])
         OP_R:                  begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_wen = 1'b1; end
         OP_I, OP_JALR:         begin use_rs1 = 1'b1; dec_wen = 1'b1; end
         OP_LOAD:               begin use_rs1 = 1'b1; dec_wen = 1'b1; dec_load = 1'b1; end
         OP_S, OP_B:            begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_JAL, OP_LUI, OP_AUIPC: dec_wen = 1'b1;
         default:               dec_ill = 1'b1;
      endcase
   end

   // x0 never sets a count, so cnt_q[0] is always zero; the explicit checks keep intent visible
   assign rs1_hz   = use_rs1 && (rs1 != '0) && (cnt_q[rs1] != 2'd0);
   assign rs2_hz   = use_rs2 && (rs2 != '0) && (cnt_q[rs2] != 2'd0);
   assign stall    = hs.id_valid && !hs.branch_taken && (rs1_hz || rs2_hz);
   assign issue    = hs.id_valid && !stall && !hs.branch_taken && !dec_ill;
   assign wr_issue = issue && dec_wen && (rd != '0);
   assign set_val  = (FWD_EN != 0) ? (dec_load ? 2'(LOAD_LAT) : 2'd0) : 2'd2;

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = (cnt_q[r] != 2'd0) ? cnt_q[r] - 2'd1 : 2'd0;
         if (wr_issue && (rd == RAW'(r)))
            cnt_d[r] = set_val;
      end
   end

   function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [RAW-1:0] rs,
                                          input logic ex_wen, input logic [RAW-1:0] ex_rd,
                                          input logic mem_wen, input logic [RAW-1:0] mem_rd);
      if (!use_rs || rs == '0)            return 2'b00;
      else if (ex_wen && rs == ex_rd)     return 2'b01;
      else if (mem_wen && rs == mem_rd)   return 2'b10;
      else                                return 2'b00;
   endfunction

   always_comb begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      if (issue && FWD_EN != 0) begin
         fwd_a_d = fwd_sel(use_rs1, rs1, ex_wen_q, ex_rd_q, mem_wen_q, mem_rd_q);
         fwd_b_d = fwd_sel(use_rs2, rs2, ex_wen_q, ex_rd_q, mem_wen_q, mem_rd_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q          <= '0;
         ex_rd_q        <= '0;
         ex_wen_q       <= 1'b0;
         mem_rd_q       <= '0;
         mem_wen_q      <= 1'b0;
         ex_valid_q     <= 1'b0;
         fwd_a_q        <= 2'b00;
         fwd_b_q        <= 2'b00;
         stall_cycles_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         ex_rd_q    <= rd;
         ex_wen_q   <= wr_issue;
         mem_rd_q   <= ex_rd_q;
         mem_wen_q  <= ex_wen_q;
         ex_valid_q <= issue;
         fwd_a_q    <= fwd_a_d;
         fwd_b_q    <= fwd_b_d;
         if (stall && !(&stall_cycles_q))
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
   end

   assign hs.stall        = stall;
   assign hs.id_flush     = hs.branch_taken;
   assign hs.illegal      = hs.id_valid && dec_ill;
   assign hs.ex_valid     = ex_valid_q;
   assign hs.ex_fwd_a     = fwd_a_q;
   assign hs.ex_fwd_b     = fwd_b_q;
   assign hs.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - bench for hazard_scoreboard_unit over three configurations
// Config 0: LOAD_LAT=1 fwd; config 1: LOAD_LAT=3 fwd, 3-bit counter; config 2: no forwarding.
module tb_hazard_scoreboard_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_scoreboard_unit_if #(.CNT_W(32)) if_a ();
   hazard_scoreboard_unit_if #(.CNT_W(3))  if_b ();
   hazard_scoreboard_unit_if #(.CNT_W(32)) if_c ();

   hazard_scoreboard_unit #(.LOAD_LAT(1), .FWD_EN(1), .CNT_W(32)) u_a (.clk_i(clk), .rst_i(rst), .hs(if_a));
   hazard_scoreboard_unit #(.LOAD_LAT(3), .FWD_EN(1), .CNT_W(3))  u_b (.clk_i(clk), .rst_i(rst), .hs(if_b));
   hazard_scoreboard_unit #(.LOAD_LAT(1), .FWD_EN(0), .CNT_W(32)) u_c (.clk_i(clk), .rst_i(rst), .hs(if_c));

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   int     c_lat [3] = '{1, 3, 1};
   int     c_fwd [3] = '{1, 1, 0};
   longint c_max [3] = '{64'hFFFF_FFFF, 7, 64'hFFFF_FFFF};

   // ready[k][r]: first cycle a consumer of r may issue; wr_at[k][r]: cycle the latest writer of r issued
   int     ready [3][32];
   int     wr_at [3][32];
   longint scnt  [3];
   logic   obs_stall [3];

   function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b0, rd, opc};
   endfunction

   function automatic void dec(input logic [31:0] ins, output logic u1, output logic u2,
                               output logic wn, output logic ld, output logic il);
      u1 = 0; u2 = 0; wn = 0; ld = 0; il = 0;
      case (ins[6:0])
         7'b0110011:             begin u1 = 1; u2 = 1; wn = 1; end
         7'b0010011, 7'b1100111: begin u1 = 1; wn = 1; end
         7'b0000011:             begin u1 = 1; wn = 1; ld = 1; end
         7'b0100011, 7'b1100011: begin u1 = 1; u2 = 1; end
         7'b1101111, 7'b0110111, 7'b0010111: wn = 1;
         default:                il = 1;
      endcase
   endfunction

   task automatic mreset(input int k);
      for (int r = 0; r < 32; r++) begin
         ready[k][r] = 0;
         wr_at[k][r] = -100;
      end
      scnt[k] = 0;
   endtask

   function automatic logic [1:0] model_fwd(input int k, input logic u, input logic [4:0] rs);
      if (c_fwd[k] == 0 || !u || rs == 0) return 2'b00;
      if (wr_at[k][rs] == cyc - 1)        return 2'b01;
      if (wr_at[k][rs] == cyc - 2)        return 2'b10;
      return 2'b00;
   endfunction

   task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s cfg%0d cyc%0d got %0h want %0h", nm, k, cyc, got, exp);
      end
   endtask

   task automatic rd_comb(input int k, output logic s, output logic f, output logic il);
      case (k)
         0:       begin s = if_a.stall; f = if_a.id_flush; il = if_a.illegal; end
         1:       begin s = if_b.stall; f = if_b.id_flush; il = if_b.illegal; end
         default: begin s = if_c.stall; f = if_c.id_flush; il = if_c.illegal; end
      endcase
   endtask

   task automatic rd_reg(input int k, output logic ev, output logic [1:0] fa,
                         output logic [1:0] fb, output logic [63:0] sc);
      case (k)
         0:       begin ev = if_a.ex_valid; fa = if_a.ex_fwd_a; fb = if_a.ex_fwd_b; sc = 64'(if_a.stall_cycles); end
         1:       begin ev = if_b.ex_valid; fa = if_b.ex_fwd_a; fb = if_b.ex_fwd_b; sc = 64'(if_b.stall_cycles); end
         default: begin ev = if_c.ex_valid; fa = if_c.ex_fwd_a; fb = if_c.ex_fwd_b; sc = 64'(if_c.stall_cycles); end
      endcase
   endtask

   // One clock: drive at negedge, check combinational outputs, then registered outputs after posedge
   task automatic step(input logic v, input logic [31:0] ins, input logic br, input logic r);
      logic u1, u2, wn, ld, il, s, f, ill, ev;
      logic [4:0] rs1, rs2, rd;
      logic [1:0] fa, fb, efa [3], efb [3];
      logic [63:0] sc;
      logic st [3];
      logic iss [3];
      dec(ins, u1, u2, wn, ld, il);
      rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
      @(negedge clk);
      rst = r;
      if_a.id_valid = v; if_a.id_instr = ins; if_a.branch_taken = br;
      if_b.id_valid = v; if_b.id_instr = ins; if_b.branch_taken = br;
      if_c.id_valid = v; if_c.id_instr = ins; if_c.branch_taken = br;
      #1;
      for (int k = 0; k < 3; k++) begin
         st[k]  = v && !br && ((u1 && rs1 != 0 && cyc < ready[k][rs1]) ||
                               (u2 && rs2 != 0 && cyc < ready[k][rs2]));
         iss[k] = v && !st[k] && !br && !il;
         efa[k] = iss[k] ? model_fwd(k, u1, rs1) : 2'b00;
         efb[k] = iss[k] ? model_fwd(k, u2, rs2) : 2'b00;
         rd_comb(k, s, f, ill);
         obs_stall[k] = s;
         if (!r) begin
            chk("stall", k, 64'(s), 64'(st[k]));
            chk("id_flush", k, 64'(f), 64'(br));
            chk("illegal", k, 64'(ill), 64'(v && il));
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            mreset(k);
            iss[k] = 0; efa[k] = 0; efb[k] = 0;
         end else begin
            if (iss[k] && wn && rd != 0) begin
               ready[k][rd] = cyc + ((c_fwd[k] == 0) ? 3 : (ld ? c_lat[k] + 1 : 1));
               wr_at[k][rd] = cyc;
            end
            if (st[k] && scnt[k] < c_max[k]) scnt[k]++;
         end
         rd_reg(k, ev, fa, fb, sc);
         chk("ex_valid", k, 64'(ev), 64'(iss[k]));
         chk("ex_fwd_a", k, 64'(fa), 64'(efa[k]));
         chk("ex_fwd_b", k, 64'(fb), 64'(efb[k]));
         chk("stall_cycles", k, sc, 64'(scnt[k]));
      end
      cyc++;
   endtask

   typedef struct {
      logic v; logic [31:0] ins; logic br;
      logic e_stall; logic e_flush; logic e_ill; logic e_exv; logic [1:0] e_fa; logic [1:0] e_fb;
   } vec_t;

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, L = 7'b0000011;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog cyc%0d got timeout want finish", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t tbl [12];
      logic s, f, il, ev;
      logic [1:0] fa, fb;
      logic [63:0] sc;
      int n;
      logic [31:0] ins;
      for (int k = 0; k < 3; k++) mreset(k);

      // expectations below are for config 0 (LOAD_LAT=1, forwarding on)
      tbl[0]  = '{1, enc(R, 1, 2, 3),  0, 0, 0, 0, 1, 2'b00, 2'b00};
      tbl[1]  = '{1, enc(R, 2, 1, 3),  0, 0, 0, 0, 1, 2'b01, 2'b00};
      tbl[2]  = '{1, enc(L, 5, 1, 0),  0, 0, 0, 0, 1, 2'b10, 2'b00};
      tbl[3]  = '{1, enc(I, 6, 5, 1),  0, 1, 0, 0, 0, 2'b00, 2'b00};
      tbl[4]  = '{1, enc(I, 6, 5, 1),  0, 0, 0, 0, 1, 2'b10, 2'b00};
      tbl[5]  = '{1, enc(R, 0, 6, 6),  0, 0, 0, 0, 1, 2'b01, 2'b01};
      tbl[6]  = '{1, enc(R, 7, 0, 0),  0, 0, 0, 0, 1, 2'b00, 2'b00};
      tbl[7]  = '{1, 32'hFFFF_FFFF,    0, 0, 0, 1, 0, 2'b00, 2'b00};
      tbl[8]  = '{1, enc(L, 8, 0, 0),  0, 0, 0, 0, 1, 2'b00, 2'b00};
      tbl[9]  = '{1, enc(R, 9, 8, 0),  1, 0, 1, 0, 0, 2'b00, 2'b00};
      tbl[10] = '{0, enc(R, 9, 8, 0),  0, 0, 0, 0, 0, 2'b00, 2'b00};
      tbl[11] = '{1, enc(R, 9, 8, 0),  0, 0, 0, 0, 1, 2'b00, 2'b00};

      if_a.id_valid = 0; if_a.id_instr = 0; if_a.branch_taken = 0;
      if_b.id_valid = 0; if_b.id_instr = 0; if_b.branch_taken = 0;
      if_c.id_valid = 0; if_c.id_instr = 0; if_c.branch_taken = 0;

      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].v, tbl[i].ins, tbl[i].br, 0);
         chk("tbl_stall", 0, 64'(obs_stall[0]), 64'(tbl[i].e_stall));
         rd_reg(0, ev, fa, fb, sc);
         chk("tbl_ex_valid", 0, 64'(ev), 64'(tbl[i].e_exv));
         chk("tbl_fwd_a", 0, 64'(fa), 64'(tbl[i].e_fa));
         chk("tbl_fwd_b", 0, 64'(fb), 64'(tbl[i].e_fb));
         rd_comb(0, s, f, il);
         chk("tbl_flush", 0, 64'(f), 64'(tbl[i].e_flush));
         chk("tbl_illegal", 0, 64'(il), 64'(tbl[i].e_ill));
      end
      chk("tbl_stall_cycles", 0, 64'(if_a.stall_cycles), 64'd1);

      // load latency 3: addi waits exactly three cycles, then reads the regfile
      step(0, 0, 0, 1);
      step(1, enc(L, 5, 0, 0), 0, 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, enc(I, 6, 5, 1), 0, 0);
         if (obs_stall[1]) n++; else break;
      end
      chk("lat3_stalls", 1, 64'(n), 64'd3);
      chk("lat3_ex_valid", 1, 64'(if_b.ex_valid), 64'd1);
      chk("lat3_fwd_a", 1, 64'(if_b.ex_fwd_a), 64'd0);

      // no forwarding: add x1 then sub x2,x1,x1 waits two cycles
      step(0, 0, 0, 1);
      step(1, enc(R, 1, 2, 3), 0, 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, enc(R, 2, 1, 1) | 32'h4000_0000, 0, 0);
         if (obs_stall[2]) n++; else break;
      end
      chk("nofwd_stalls", 2, 64'(n), 64'd2);
      chk("nofwd_fwd_a", 2, 64'(if_c.ex_fwd_a), 64'd0);
      chk("nofwd_fwd_b", 2, 64'(if_c.ex_fwd_b), 64'd0);

      // reset in the middle of a load-use stall drops the hazard and clears the counter
      step(0, 0, 0, 1);
      step(1, enc(L, 5, 0, 0), 0, 0);
      step(1, enc(I, 6, 5, 1), 0, 0);
      chk("pre_rst_stall", 1, 64'(obs_stall[1]), 64'd1);
      step(1, enc(I, 6, 5, 1), 0, 1);
      step(1, enc(I, 6, 5, 1), 0, 0);
      chk("post_rst_stall", 1, 64'(obs_stall[1]), 64'd0);
      chk("post_rst_count", 1, 64'(if_b.stall_cycles), 64'd0);

      for (int i = 0; i < 400; i++) begin
         logic [4:0] a, b, d;
         a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0, 1:    ins = enc(R, d, a, b);
            2:       ins = enc(I, d, a, b);
            3, 4:    ins = enc(L, d, a, b);
            5:       ins = enc(7'b0100011, d, a, b);
            6:       ins = enc(7'b1100011, d, a, b);
            7:       ins = enc(($urandom_range(0, 1) != 0) ? 7'b1101111 : 7'b1100111, d, a, b);
            8:       ins = enc(($urandom_range(0, 1) != 0) ? 7'b0110111 : 7'b1111111, d, a, b);
            default: ins = $urandom;
         endcase
         step($urandom_range(0, 7) != 0, ins, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
